// File: rtl/nios_sys_nios2_processor_oci_dct_packer_pkg.sv
// Shared constants for the OCI debug-capture-trace word path: atom geometry,
// counter widths, atom codes and the slot-to-bit-offset helper.
package nios_sys_nios2_processor_oci_dct_packer_pkg;

  localparam int ATOM_W = 2;
  localparam int SLOTS  = 15;
  localparam int CNT_W  = 4;
  localparam int WCNT_W = 16;
  localparam int BUF_W  = ATOM_W * SLOTS;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

  // Atom codes; the trace sink and checker decode the same values.
  typedef enum logic [ATOM_W-1:0] {
    ATOM_NONE   = 2'b00,
    ATOM_SEQ    = 2'b01,
    ATOM_BRANCH = 2'b10,
    ATOM_SYNC   = 2'b11
  } atom_code_e;

  function automatic int slot_off(input logic [CNT_W-1:0] k);
    return ATOM_W * int'(k);
  endfunction

endpackage

// File: rtl/nios_sys_nios2_processor_oci_dct_outreg.sv
// One-entry valid/ready holding register for packed DCT words, with a
// wrapping count of words loaded.
module nios_sys_nios2_processor_oci_dct_outreg
  import nios_sys_nios2_processor_oci_dct_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BUF_W-1:0]  load_buf,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              dct_ready,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  output logic [WCNT_W-1:0] words_emitted,
  output logic              out_free
);

  // Handshake: a word transfers on any rising edge where dct_valid && dct_ready;
  // while dct_valid && !dct_ready the word and its count are held unchanged.
  assign out_free = !dct_valid || dct_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer    <= '0;
      dct_count     <= '0;
      dct_valid     <= 1'b0;
      words_emitted <= '0;
    end else if (load) begin
      dct_buffer    <= load_buf;
      dct_count     <= load_cnt;
      dct_valid     <= 1'b1;
      words_emitted <= words_emitted + WCNT_W'(1);
    end else if (dct_valid && dct_ready) begin
      // Buffer/count keep their last value after handoff.
      dct_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_sys_nios2_processor_oci_dct_packer.sv
// Packs 2-bit trace atoms LSB-first into 30-bit words (15 slots) and hands
// them to the DCT sink through a one-entry output register.
module nios_sys_nios2_processor_oci_dct_packer
  import nios_sys_nios2_processor_oci_dct_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ATOM_W-1:0] atom_in,
  input  logic              atom_valid,
  output logic              atom_ready,
  input  logic              flush,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              dct_valid,
  input  logic              dct_ready,
  output logic              idle,
  output logic [WCNT_W-1:0] words_emitted
);

  logic [BUF_W-1:0] asm_buf, asm_buf_n;
  logic [CNT_W-1:0] asm_cnt, asm_cnt_n, base_cnt;
  logic             flush_pend, flush_pend_n;
  logic             out_free, xfer, accept;

  // Transfer decision uses registered state only, so atom_ready has no path
  // from atom_valid or flush.
  assign xfer       = out_free && ((asm_cnt == FULL_CNT) || (flush_pend && (asm_cnt != '0)));
  assign atom_ready = (asm_cnt < FULL_CNT) || xfer;
  assign accept     = atom_valid && atom_ready;
  assign base_cnt   = xfer ? '0 : asm_cnt;
  assign idle       = (asm_cnt == '0) && !flush_pend && !dct_valid;

  always_comb begin
    asm_buf_n = xfer ? '0 : asm_buf;
    asm_cnt_n = base_cnt;
    if (accept) begin
      for (int k = 0; k < SLOTS; k++) begin
        if (base_cnt == CNT_W'(k)) asm_buf_n[slot_off(CNT_W'(k)) +: ATOM_W] = atom_in;
      end
      asm_cnt_n = base_cnt + CNT_W'(1);
    end
  end

  // A flush raised on a transfer cycle applies to the fresh assembly; a
  // pending flush over an empty assembly is dropped without emitting.
  assign flush_pend_n = flush || (flush_pend && !xfer && (asm_cnt != '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_buf    <= '0;
      asm_cnt    <= '0;
      flush_pend <= 1'b0;
    end else begin
      asm_buf    <= asm_buf_n;
      asm_cnt    <= asm_cnt_n;
      flush_pend <= flush_pend_n;
    end
  end

  nios_sys_nios2_processor_oci_dct_outreg u_outreg (
    .clk           (clk),
    .reset         (reset),
    .load          (xfer),
    .load_buf      (asm_buf),
    .load_cnt      (asm_cnt),
    .dct_ready     (dct_ready),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .dct_valid     (dct_valid),
    .words_emitted (words_emitted),
    .out_free      (out_free)
  );

endmodule

// File: tb/tb_nios_sys_nios2_processor_oci_dct_packer.sv
// Directed bench for the DCT packer: a per-cycle vector table plus
// hand-written backpressure, same-cycle-flush and mid-word reset sequences.
module tb_nios_sys_nios2_processor_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  atom_in = '0;
  logic        atom_valid = 1'b0;
  logic        atom_ready;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready = 1'b1;
  logic        idle;
  logic [15:0] words_emitted;

  int n_checks = 0;
  int n_err    = 0;

  // {count, buffer} of each word the sink should receive, in order
  logic [33:0] exp_q[$];

  typedef struct {
    logic        av;
    logic [1:0]  ai;
    logic        fl;
    logic        rd;
    logic        ar;
    logic        v;
    logic [29:0] buf_e;
    logic [3:0]  cnt;
    logic        idl;
    logic [15:0] words;
  } vec_t;

  vec_t vecs[$];

  nios_sys_nios2_processor_oci_dct_packer dut (
    .clk           (clk),
    .reset         (reset),
    .atom_in       (atom_in),
    .atom_valid    (atom_valid),
    .atom_ready    (atom_ready),
    .flush         (flush),
    .dct_buffer    (dct_buffer),
    .dct_count     (dct_count),
    .dct_valid     (dct_valid),
    .dct_ready     (dct_ready),
    .idle          (idle),
    .words_emitted (words_emitted)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every handshake must match the head of exp_q
  always @(negedge clk) begin
    if (!reset && dct_valid && dct_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected word", {dct_count, dct_buffer[27:0]}, 32'hFFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("word count", 32'(dct_count), 32'(e[33:30]));
        check("word buffer", 32'(dct_buffer), 32'(e[29:0]));
      end
    end
  end

  task automatic add(input logic av, input logic [1:0] ai, input logic fl, input logic rd,
                     input logic ar, input logic v, input logic [29:0] b, input logic [3:0] c,
                     input logic idl, input logic [15:0] w);
    vec_t r;
    r.av = av; r.ai = ai; r.fl = fl; r.rd = rd; r.ar = ar;
    r.v = v; r.buf_e = b; r.cnt = c; r.idl = idl; r.words = w;
    vecs.push_back(r);
  endtask

  // driver: apply inputs for one cycle, return at posedge+1
  task automatic drive_cycle(input logic av, input logic [1:0] ai, input logic fl);
    atom_valid = av;
    atom_in    = ai;
    flush      = fl;
    @(posedge clk); #1;
    atom_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 20 && !idle; c++) begin
      @(posedge clk); #1;
    end
    check(name, 32'(idle), 32'd1);
  endtask

  initial begin
    int accepted;
    logic unstable, held_seen;
    logic [29:0] held_buf;
    logic [3:0]  held_cnt;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset dct_valid", 32'(dct_valid), 32'd0);
    check("reset dct_buffer", 32'(dct_buffer), 32'd0);
    check("reset dct_count", 32'(dct_count), 32'd0);
    check("reset words", 32'(words_emitted), 32'd0);
    check("reset idle", 32'(idle), 32'd1);
    check("reset atom_ready", 32'(atom_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // table: 15 x 01 full word, then 3,2,1 + flush, then empty flush
    for (int i = 0; i < 15; i++) add(1, 2'b01, 0, 1, 1, 0, 30'h0, 4'd0, 0, 16'd0);
    add(0, 2'b00, 0, 1, 1, 1, 30'h15555555, 4'd15, 0, 16'd1);
    add(0, 2'b00, 0, 1, 1, 0, 30'h15555555, 4'd15, 1, 16'd1);
    add(1, 2'b11, 0, 1, 1, 0, 30'h15555555, 4'd15, 0, 16'd1);
    add(1, 2'b10, 0, 1, 1, 0, 30'h15555555, 4'd15, 0, 16'd1);
    add(1, 2'b01, 0, 1, 1, 0, 30'h15555555, 4'd15, 0, 16'd1);
    add(0, 2'b00, 1, 1, 1, 0, 30'h15555555, 4'd15, 0, 16'd1);
    add(0, 2'b00, 0, 1, 1, 1, 30'h0000001B, 4'd3, 0, 16'd2);
    add(0, 2'b00, 0, 1, 1, 0, 30'h0000001B, 4'd3, 1, 16'd2);
    add(0, 2'b00, 0, 1, 1, 0, 30'h0000001B, 4'd3, 1, 16'd2);
    add(0, 2'b00, 1, 1, 1, 0, 30'h0000001B, 4'd3, 0, 16'd2);
    add(0, 2'b00, 0, 1, 1, 0, 30'h0000001B, 4'd3, 1, 16'd2);
    add(0, 2'b00, 0, 1, 1, 0, 30'h0000001B, 4'd3, 1, 16'd2);
    exp_q.push_back({4'd15, 30'h15555555});
    exp_q.push_back({4'd3, 30'h0000001B});

    foreach (vecs[i]) begin
      atom_valid = vecs[i].av;
      atom_in    = vecs[i].ai;
      flush      = vecs[i].fl;
      dct_ready  = vecs[i].rd;
      @(negedge clk);
      check($sformatf("row%0d atom_ready", i), 32'(atom_ready), 32'(vecs[i].ar));
      @(posedge clk); #1;
      check($sformatf("row%0d dct_valid", i), 32'(dct_valid), 32'(vecs[i].v));
      check($sformatf("row%0d dct_buffer", i), 32'(dct_buffer), 32'(vecs[i].buf_e));
      check($sformatf("row%0d dct_count", i), 32'(dct_count), 32'(vecs[i].cnt));
      check($sformatf("row%0d idle", i), 32'(idle), 32'(vecs[i].idl));
      check($sformatf("row%0d words", i), 32'(words_emitted), 32'(vecs[i].words));
    end
    atom_valid = 1'b0;
    flush      = 1'b0;

    // backpressure: 32 atoms of 10 offered with the sink stalled
    dct_ready  = 1'b0;
    atom_valid = 1'b1;
    atom_in    = 2'b10;
    accepted   = 0;
    unstable   = 1'b0;
    held_seen  = 1'b0;
    held_buf   = '0;
    held_cnt   = '0;
    for (int c = 0; c < 40 && accepted < 32; c++) begin
      @(negedge clk);
      if (atom_ready) accepted++;
      if (dct_valid && !dct_ready) begin
        if (held_seen && (dct_buffer != held_buf || dct_count != held_cnt)) unstable = 1'b1;
        held_buf  = dct_buffer;
        held_cnt  = dct_count;
        held_seen = 1'b1;
      end
      @(posedge clk); #1;
    end
    check("bp accepted while stalled", 32'(accepted), 32'd30);
    check("bp atom_ready full", 32'(atom_ready), 32'd0);
    check("bp dct_valid held", 32'(dct_valid), 32'd1);
    check("bp held buffer", 32'(dct_buffer), 32'h2AAAAAAA);
    check("bp held count", 32'(dct_count), 32'd15);
    check("bp held stable", 32'(unstable), 32'd0);
    check("bp words", 32'(words_emitted), 32'd3);

    exp_q.push_back({4'd15, 30'h2AAAAAAA});
    exp_q.push_back({4'd15, 30'h2AAAAAAA});
    dct_ready = 1'b1;
    for (int c = 0; c < 10 && accepted < 32; c++) begin
      @(negedge clk);
      if (atom_ready) accepted++;
      @(posedge clk); #1;
    end
    atom_valid = 1'b0;
    check("bp accepted total", 32'(accepted), 32'd32);
    check("bp drained valid", 32'(dct_valid), 32'd0);
    check("bp drained words", 32'(words_emitted), 32'd4);
    check("bp drained queue", 32'(exp_q.size()), 32'd0);

    // leftover two atoms flushed as a partial word
    exp_q.push_back({4'd2, 30'h0000000A});
    drive_cycle(0, 2'b00, 1);
    wait_idle("bp flush idle");
    check("bp flush words", 32'(words_emitted), 32'd5);

    // atom accepted in the same cycle as flush joins the flushed word
    exp_q.push_back({4'd3, 30'h0000002D});
    drive_cycle(1, 2'b01, 0);
    drive_cycle(1, 2'b11, 0);
    drive_cycle(1, 2'b10, 1);
    wait_idle("same-cycle flush idle");
    check("same-cycle flush words", 32'(words_emitted), 32'd6);
    check("same-cycle bits 5:4", 32'(dct_buffer[5:4]), 32'd2);

    // reset with a word held and 7 atoms assembled
    dct_ready  = 1'b0;
    atom_valid = 1'b1;
    atom_in    = 2'b11;
    accepted   = 0;
    for (int c = 0; c < 40 && accepted < 22; c++) begin
      @(negedge clk);
      if (atom_ready) accepted++;
      @(posedge clk); #1;
    end
    atom_valid = 1'b0;
    check("pre-reset accepted", 32'(accepted), 32'd22);
    check("pre-reset held", 32'(dct_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async reset dct_valid", 32'(dct_valid), 32'd0);
    check("async reset dct_buffer", 32'(dct_buffer), 32'd0);
    check("async reset dct_count", 32'(dct_count), 32'd0);
    check("async reset words", 32'(words_emitted), 32'd0);
    check("async reset idle", 32'(idle), 32'd1);
    @(posedge clk); #1;
    reset     = 1'b0;
    dct_ready = 1'b1;

    exp_q.push_back({4'd15, 30'h15555555});
    for (int i = 0; i < 15; i++) drive_cycle(1, 2'b01, 0);
    wait_idle("post-reset idle");
    check("post-reset words", 32'(words_emitted), 32'd1);
    check("final queue empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
